// File: rtl/collision_scheduler.sv
// Two-player collision checker that time-shares one external equality comparator.
// Each accepted tick checks player 1, then player 2, then updates crash flags and lives.
module collision_scheduler #(
  parameter int DATAWIDTH = 8,
  parameter int LIVES     = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_InLow,
  input  logic                 start,
  input  logic                 clear,
  input  logic [DATAWIDTH-1:0] fila0,
  input  logic [DATAWIDTH-1:0] posjug1,
  input  logic [DATAWIDTH-1:0] posjug2,
  input  logic                 jug1_active,
  input  logic                 jug2_active,
  input  logic                 cmp_eq,
  output logic [DATAWIDTH-1:0] cmp_a,
  output logic [DATAWIDTH-1:0] cmp_b,
  output logic                 busy,
  output logic                 done,
  output logic                 crash1,
  output logic                 crash2,
  output logic [1:0]           lives1,
  output logic [1:0]           lives2,
  output logic                 gameover
);

  typedef enum logic [1:0] {IDLE, CHK1, CHK2, DONE} stateT;

  localparam logic [1:0] LIVESINIT = 2'(LIVES);

  stateT                stateReg, stateNext;
  logic [DATAWIDTH-1:0] filaSnap, pos1Snap, pos2Snap;
  logic                 act1Snap, act2Snap;
  logic                 hit1Reg;
  logic                 hit2;
  logic                 accept;

  // gameover looks at the live enables so a dropped player does not keep the game alive
  assign gameover = (!jug1_active || lives1 == 2'd0) &&
                    (!jug2_active || lives2 == 2'd0) &&
                    (jug1_active || jug2_active);

  assign accept = (stateReg == IDLE) && start && !gameover;
  assign hit2   = cmp_eq && act2Snap;

  always_comb begin
    stateNext = stateReg;
    cmp_a     = '0;
    cmp_b     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (accept) stateNext = CHK1;
      end
      CHK1: begin
        stateNext = CHK2;
        cmp_a     = filaSnap;
        cmp_b     = pos1Snap;
        busy      = 1'b1;
      end
      CHK2: begin
        stateNext = DONE;
        cmp_a     = filaSnap;
        cmp_b     = pos2Snap;
        busy      = 1'b1;
      end
      DONE: begin
        stateNext = IDLE;
        busy      = 1'b1;
        done      = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      stateReg <= IDLE;
      filaSnap <= '0;
      pos1Snap <= '0;
      pos2Snap <= '0;
      act1Snap <= 1'b0;
      act2Snap <= 1'b0;
      hit1Reg  <= 1'b0;
      crash1   <= 1'b0;
      crash2   <= 1'b0;
      lives1   <= LIVESINIT;
      lives2   <= LIVESINIT;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        filaSnap <= fila0;
        pos1Snap <= posjug1;
        pos2Snap <= posjug2;
        act1Snap <= jug1_active;
        act2Snap <= jug2_active;
      end
      // A reload coincides with an accept at most; the decrement happens two edges later
      if (stateReg == IDLE && clear) begin
        lives1 <= LIVESINIT;
        lives2 <= LIVESINIT;
        crash1 <= 1'b0;
        crash2 <= 1'b0;
      end
      if (stateReg == CHK1) hit1Reg <= cmp_eq && act1Snap;
      if (stateReg == CHK2) begin
        crash1 <= hit1Reg;
        crash2 <= hit2;
        if (hit1Reg && lives1 != 2'd0) lives1 <= lives1 - 2'd1;
        if (hit2 && lives2 != 2'd0) lives2 <= lives2 - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: directed table, corner sequences and randomized ticks
// checked against a per-tick model of lives, crash flags and gameover.
module tb_collision_scheduler;
  localparam int W = 8;
  localparam int L = 3;

  logic         CLOCK_50, RESET_InLow, start, clear;
  logic [W-1:0] fila0, posjug1, posjug2;
  logic         jug1_active, jug2_active, cmp_eq;
  logic [W-1:0] cmp_a, cmp_b;
  logic         busy, done, crash1, crash2, gameover;
  logic [1:0]   lives1, lives2;

  // the shared comparator lives outside the block
  assign cmp_eq = (cmp_a == cmp_b);

  collision_scheduler #(.DATAWIDTH(W), .LIVES(L)) dut (
    .CLOCK_50(CLOCK_50), .RESET_InLow(RESET_InLow), .start(start), .clear(clear),
    .fila0(fila0), .posjug1(posjug1), .posjug2(posjug2),
    .jug1_active(jug1_active), .jug2_active(jug2_active), .cmp_eq(cmp_eq),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .busy(busy), .done(done),
    .crash1(crash1), .crash2(crash2), .lives1(lives1), .lives2(lives2),
    .gameover(gameover)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int lives1M = L, lives2M = L;
  bit crash1M = 0, crash2M = 0;

  typedef struct {
    logic [W-1:0] f, p1, p2;
    bit a1, a2;
    bit c1, c2;
    int l1, l2;
    bit go;
  } vecT;
  vecT tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit gmModel(input int l1, input int l2, input bit a1, input bit a2);
    return (!a1 || l1 == 0) && (!a2 || l2 == 0) && (a1 || a2);
  endfunction

  task automatic clearPulse(input string tag);
    @(negedge CLOCK_50);
    clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    lives1M = L; lives2M = L; crash1M = 0; crash2M = 0;
    chk({tag, ".lives1"}, int'(lives1), lives1M);
    chk({tag, ".lives2"}, int'(lives2), lives2M);
    chk({tag, ".crash1"}, int'(crash1), 0);
    chk({tag, ".gameover"}, int'(gameover), int'(gmModel(lives1M, lives2M, jug1_active, jug2_active)));
    $display("tick %s: clear -> lives %0d/%0d", tag, lives1, lives2);
  endtask

  task automatic doCheck(input logic [W-1:0] f, input logic [W-1:0] p1, input logic [W-1:0] p2,
                         input bit a1, input bit a2, input bit clr, input bit midZero,
                         input bit clrChk2, input string tag);
    bit expAccept, h1, h2;
    @(negedge CLOCK_50);
    fila0 = f; posjug1 = p1; posjug2 = p2; jug1_active = a1; jug2_active = a2;
    start = 1'b1; clear = clr;
    expAccept = !gmModel(lives1M, lives2M, a1, a2);
    if (clr) begin
      lives1M = L; lives2M = L; crash1M = 0; crash2M = 0;
    end
    @(negedge CLOCK_50);
    start = 1'b0; clear = 1'b0;
    if (!expAccept) begin
      chk({tag, ".refusedBusy"}, int'(busy), 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge CLOCK_50);
        chk({tag, ".refusedDone"}, int'(done), 0);
      end
      chk({tag, ".lives1"}, int'(lives1), lives1M);
      chk({tag, ".lives2"}, int'(lives2), lives2M);
      $display("tick %s: refused, lives %0d/%0d busy=%0d", tag, lives1, lives2, busy);
      return;
    end
    chk({tag, ".chk1Busy"}, int'(busy), 1);
    chk({tag, ".chk1CmpA"}, int'(cmp_a), int'(f));
    chk({tag, ".chk1CmpB"}, int'(cmp_b), int'(p1));
    chk({tag, ".chk1Done"}, int'(done), 0);
    if (midZero) fila0 = '0;
    @(negedge CLOCK_50);
    chk({tag, ".chk2CmpA"}, int'(cmp_a), int'(f));
    chk({tag, ".chk2CmpB"}, int'(cmp_b), int'(p2));
    if (clrChk2) clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    fila0 = f;
    h1 = a1 && (f == p1);
    h2 = a2 && (f == p2);
    crash1M = h1; crash2M = h2;
    if (h1 && lives1M > 0) lives1M--;
    if (h2 && lives2M > 0) lives2M--;
    chk({tag, ".done"}, int'(done), 1);
    chk({tag, ".doneCmpA"}, int'(cmp_a), 0);
    chk({tag, ".crash1"}, int'(crash1), int'(crash1M));
    chk({tag, ".crash2"}, int'(crash2), int'(crash2M));
    chk({tag, ".lives1"}, int'(lives1), lives1M);
    chk({tag, ".lives2"}, int'(lives2), lives2M);
    chk({tag, ".gameover"}, int'(gameover), int'(gmModel(lives1M, lives2M, a1, a2)));
    $display("tick %s: f=%h p1=%h p2=%h act=%0d%0d crash=%0d%0d lives=%0d/%0d go=%0d",
             tag, f, p1, p2, a1, a2, crash1, crash2, lives1, lives2, gameover);
    @(negedge CLOCK_50);
    chk({tag, ".doneOneCycle"}, int'(done), 0);
    chk({tag, ".idleBusy"}, int'(busy), 0);
  endtask

  initial begin
    logic [W-1:0] f, p1, p2, snap, drivenFila;
    bit a1, a2, clr, prevBusy;
    int doneCount, acceptCount;

    tbl[0] = '{8'h10, 8'h10, 8'h01, 1, 1, 1, 0, 2, 3, 0};
    tbl[1] = '{8'h20, 8'h01, 8'h20, 1, 1, 0, 1, 2, 2, 0};
    tbl[2] = '{8'h04, 8'h04, 8'h04, 1, 1, 1, 1, 1, 1, 0};
    tbl[3] = '{8'h04, 8'h04, 8'h04, 0, 1, 0, 1, 1, 0, 1};
    tbl[4] = '{8'h08, 8'h08, 8'h01, 1, 1, 1, 0, 0, 0, 1};
    tbl[5] = '{8'h08, 8'h08, 8'h01, 1, 1, 1, 0, 0, 0, 1};

    RESET_InLow = 1'b0; start = 1'b0; clear = 1'b0;
    fila0 = '0; posjug1 = '0; posjug2 = '0; jug1_active = 1'b1; jug2_active = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.cmpA", int'(cmp_a), 0);
    chk("reset.cmpB", int'(cmp_b), 0);
    chk("reset.lives1", int'(lives1), L);
    chk("reset.lives2", int'(lives2), L);
    chk("reset.crash1", int'(crash1), 0);
    chk("reset.gameover", int'(gameover), 0);
    $display("tick reset: lives %0d/%0d busy=%0d", lives1, lives2, busy);
    RESET_InLow = 1'b1;

    // directed table, including saturation and refusal once every active player is out
    for (int i = 0; i < 6; i++) begin
      doCheck(tbl[i].f, tbl[i].p1, tbl[i].p2, tbl[i].a1, tbl[i].a2, 0, 0, 0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.tCrash1", i), int'(crash1), int'(tbl[i].c1));
      chk($sformatf("tbl%0d.tCrash2", i), int'(crash2), int'(tbl[i].c2));
      chk($sformatf("tbl%0d.tLives1", i), int'(lives1), tbl[i].l1);
      chk($sformatf("tbl%0d.tLives2", i), int'(lives2), tbl[i].l2);
      chk($sformatf("tbl%0d.tGameover", i), int'(gameover), int'(tbl[i].go));
    end

    clearPulse("clrIdle");
    chk("clrIdle.gameoverLow", int'(gameover), 0);

    // player 1 alone loses all lives; the fourth tick must be refused
    for (int i = 0; i < 4; i++)
      doCheck(8'h10, 8'h10, 8'h01, 1, 0, 0, 0, 0, $sformatf("solo%0d", i));
    chk("solo.lives1", int'(lives1), 0);
    chk("solo.gameover", int'(gameover), 1);

    clearPulse("clr2");
    doCheck(8'h10, 8'h10, 8'h01, 1, 1, 0, 1, 0, "snapFila");
    doCheck(8'h02, 8'h02, 8'h40, 1, 1, 0, 0, 1, "clrInChk2");
    doCheck(8'h40, 8'h01, 8'h40, 1, 1, 1, 0, 0, "clrWithStart");

    // start held high: one accept every 4 cycles, operands frozen during a check
    clearPulse("clr3");
    @(negedge CLOCK_50);
    posjug1 = 8'h80; posjug2 = 8'h80; jug1_active = 1; jug2_active = 1;
    drivenFila = 8'($urandom_range(0, 127));
    fila0 = drivenFila; start = 1'b1;
    prevBusy = 0; doneCount = 0; acceptCount = 0; snap = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK_50);
      if (busy && !prevBusy) begin
        snap = drivenFila;
        acceptCount++;
      end
      if (busy && cmp_b != 0) chk("held.cmpA", int'(cmp_a), int'(snap));
      if (done) doneCount++;
      prevBusy = busy;
      drivenFila = 8'($urandom_range(0, 127));
      fila0 = drivenFila;
    end
    start = 1'b0;
    crash1M = 0; crash2M = 0;
    chk("held.accepts", acceptCount, 4);
    chk("held.dones", doneCount, 4);
    chk("held.lives1", int'(lives1), lives1M);
    $display("tick held: accepts=%0d dones=%0d", acceptCount, doneCount);

    // asynchronous reset while a player-1 hit is pending
    @(negedge CLOCK_50);
    fila0 = 8'h10; posjug1 = 8'h10; posjug2 = 8'h01; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    @(negedge CLOCK_50);
    RESET_InLow = 1'b0;
    #1;
    chk("rstMid.busy", int'(busy), 0);
    chk("rstMid.done", int'(done), 0);
    chk("rstMid.cmpA", int'(cmp_a), 0);
    chk("rstMid.cmpB", int'(cmp_b), 0);
    chk("rstMid.lives1", int'(lives1), L);
    chk("rstMid.crash1", int'(crash1), 0);
    lives1M = L; lives2M = L; crash1M = 0; crash2M = 0;
    @(negedge CLOCK_50);
    RESET_InLow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      chk("rstMid.noDone", int'(done), 0);
    end
    $display("tick rstMid: lives1=%0d done=%0d", lives1, done);
    doCheck(8'h10, 8'h10, 8'h01, 1, 1, 0, 0, 0, "afterRst");

    for (int n = 0; n < 40; n++) begin
      f  = 8'(1 << $urandom_range(0, 7));
      p1 = ($urandom_range(0, 2) == 0) ? f : 8'(1 << $urandom_range(0, 7));
      p2 = ($urandom_range(0, 2) == 0) ? f : 8'(1 << $urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) != 0);
      a2 = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0) ||
            (gmModel(lives1M, lives2M, a1, a2) && $urandom_range(0, 1) == 1);
      doCheck(f, p1, p2, a1, a2, clr, 0, 0, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
